// File: rtl/stream_pattern_pkg.sv
// Shared types and the PRBS31 word generator for the dual-stream pattern source.
package stream_pattern_pkg;

  typedef enum logic {
    PAT_COUNTER = 1'b0,
    PAT_PRBS31  = 1'b1
  } pat_mode_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } gen_state_e;

  // x^31 + x^28 + 1, expressed as state bit positions
  localparam int PRBS31_TAP_HI = 30;
  localparam int PRBS31_TAP_LO = 27;

  function automatic logic [30:0] prbs31_seed(input logic [31:0] s);
    return (s[30:0] == 31'd0) ? 31'd1 : s[30:0];
  endfunction

  // The low 31 bits of the returned word are also the LFSR state after the
  // 32 steps, so the next word is prbs31_step32(word[30:0]).
  function automatic logic [31:0] prbs31_step32(input logic [30:0] s);
    logic [30:0] r;
    logic        b;
    logic [31:0] w;
    r = s;
    w = '0;
    for (int k = 0; k < 32; k++) begin
      b       = r[PRBS31_TAP_HI] ^ r[PRBS31_TAP_LO];
      r       = {r[29:0], b};
      w[31-k] = b;
    end
    return w;
  endfunction

endpackage

// File: rtl/stream_pattern_lane.sv
// One AXI-Stream output: NLINKS pattern lanes, valid/hold, word counter and
// optional one-shot bit-0 corruption of a selected lane.
module stream_pattern_lane
  import stream_pattern_pkg::*;
#(
  parameter int NLINKS    = 1,
  parameter int CNT_WIDTH = 32,
  parameter bit INJ_EN    = 1'b0
) (
  input  logic                   clk,
  input  logic                   areset,
  input  logic                   load_i,
  input  logic                   abort_i,
  input  pat_mode_e              mode_i,
  input  logic [31:0]            seed_i,
  input  logic [CNT_WIDTH-1:0]   burst_len_i,
  input  logic                   inj_i,
  input  logic [7:0]             inj_link_i,
  input  logic                   tready_i,
  output logic [NLINKS*32-1:0]   tdata_o,
  output logic                   tvalid_o,
  output logic                   vld_d_o,
  output logic                   fin_d_o,
  output logic [CNT_WIDTH-1:0]   cnt_o,
  output logic [CNT_WIDTH-1:0]   inj_cnt_o
);

  localparam int LW = (NLINKS > 1) ? $clog2(NLINKS) : 1;
  localparam logic [CNT_WIDTH-1:0] CNT_ONE = 1;

  logic [NLINKS-1:0][31:0] data_q, data_d, mask;
  logic                    tvalid_q, tvalid_d;
  logic [CNT_WIDTH-1:0]    cnt_q, cnt_d, inj_cnt_q, inj_cnt_d, len_q, len_d;
  logic [CNT_WIDTH-1:0]    cnt_inc, inj_inc;
  logic                    pend_q, pend_d, corrupt_q, corrupt_d, inj_take, hs;
  logic [LW-1:0]           link_q, link_d;
  pat_mode_e               mode_q, mode_d;

  always_comb begin
    hs       = tvalid_q && tready_i;
    cnt_inc  = (&cnt_q) ? cnt_q : cnt_q + CNT_ONE;
    inj_inc  = (&inj_cnt_q) ? inj_cnt_q : inj_cnt_q + CNT_ONE;
    // A pulse while already pending is absorbed; out-of-range lanes never arm.
    inj_take = INJ_EN && inj_i && !pend_q && (32'(inj_link_i) < 32'(NLINKS));
    pend_d   = inj_take || (pend_q && !(hs && corrupt_q));
    link_d   = inj_take ? inj_link_i[LW-1:0] : link_q;

    data_d    = data_q;
    tvalid_d  = tvalid_q;
    cnt_d     = cnt_q;
    inj_cnt_d = inj_cnt_q;
    corrupt_d = corrupt_q;
    mode_d    = mode_q;
    len_d     = len_q;

    if (load_i) begin
      mode_d    = mode_i;
      len_d     = burst_len_i;
      cnt_d     = '0;
      inj_cnt_d = '0;
      tvalid_d  = 1'b1;
      corrupt_d = pend_d;
      for (int i = 0; i < NLINKS; i++)
        data_d[i] = (mode_i == PAT_PRBS31) ? prbs31_step32(prbs31_seed(seed_i ^ 32'(i)))
                                           : seed_i + 32'(i);
    end else if (hs) begin
      cnt_d = cnt_inc;
      if (corrupt_q) inj_cnt_d = inj_inc;
      for (int i = 0; i < NLINKS; i++)
        data_d[i] = (mode_q == PAT_PRBS31) ? prbs31_step32(data_q[i][30:0])
                                           : data_q[i] + 32'd1;
      tvalid_d  = !abort_i && !((len_q != '0) && (cnt_inc == len_q));
      // Corruption is only decided when a fresh word is presented, so a held
      // word is never altered mid-stall.
      corrupt_d = tvalid_d && pend_d;
    end

    fin_d_o = (len_q != '0) && (cnt_d == len_q);
    vld_d_o = tvalid_d;
  end

  always_comb begin
    mask = '0;
    if (corrupt_q) mask[link_q][0] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (areset) begin
      data_q    <= '0;
      tvalid_q  <= 1'b0;
      cnt_q     <= '0;
      inj_cnt_q <= '0;
      len_q     <= '0;
      pend_q    <= 1'b0;
      corrupt_q <= 1'b0;
      link_q    <= '0;
      mode_q    <= PAT_COUNTER;
    end else begin
      data_q    <= data_d;
      tvalid_q  <= tvalid_d;
      cnt_q     <= cnt_d;
      inj_cnt_q <= inj_cnt_d;
      len_q     <= len_d;
      pend_q    <= pend_d;
      corrupt_q <= corrupt_d;
      link_q    <= link_d;
      mode_q    <= mode_d;
    end
  end

  assign tdata_o   = data_q ^ mask;
  assign tvalid_o  = tvalid_q;
  assign cnt_o     = cnt_q;
  assign inj_cnt_o = inj_cnt_q;

endmodule

// File: rtl/stream_pattern_gen.sv
// Dual AXI-Stream pattern source (counter / PRBS31) with one-shot error
// injection on stream 1, feeding the dual-stream comparator via links.
module stream_pattern_gen
  import stream_pattern_pkg::*;
#(
  parameter int TDATA_WIDTH = 32,
  parameter int CNT_WIDTH   = 32
) (
  input  logic                   clk,
  input  logic                   areset,
  input  logic                   start,
  input  logic                   stop,
  input  logic                   mode,
  input  logic [31:0]            seed,
  input  logic [CNT_WIDTH-1:0]   burst_len,
  input  logic                   inject_err,
  input  logic [7:0]             inject_link,
  output logic [TDATA_WIDTH-1:0] M_AXIS_0_TDATA,
  output logic                   M_AXIS_0_TVALID,
  input  logic                   M_AXIS_0_TREADY,
  output logic [TDATA_WIDTH-1:0] M_AXIS_1_TDATA,
  output logic                   M_AXIS_1_TVALID,
  input  logic                   M_AXIS_1_TREADY,
  output logic                   busy,
  output logic                   done,
  output logic [CNT_WIDTH-1:0]   word_count,
  output logic [CNT_WIDTH-1:0]   inject_count
);

  localparam int NLINKS = TDATA_WIDTH / 32;

  gen_state_e           state_q;
  logic                 abort_q, abort_eff, load;
  logic                 v0_d, v1_d, f0_d, f1_d;
  logic [CNT_WIDTH-1:0] unused_inj_cnt0, unused_cnt1;

  assign load      = start && (state_q != ST_RUN);
  // stop acts in its own cycle so a word handshaking alongside it is the last
  assign abort_eff = abort_q || (stop && (state_q == ST_RUN));

  stream_pattern_lane #(.NLINKS(NLINKS), .CNT_WIDTH(CNT_WIDTH), .INJ_EN(1'b0)) u_lane0 (
    .clk, .areset,
    .load_i(load), .abort_i(abort_eff), .mode_i(pat_mode_e'(mode)),
    .seed_i(seed), .burst_len_i(burst_len),
    .inj_i(1'b0), .inj_link_i(8'd0),
    .tready_i(M_AXIS_0_TREADY), .tdata_o(M_AXIS_0_TDATA), .tvalid_o(M_AXIS_0_TVALID),
    .vld_d_o(v0_d), .fin_d_o(f0_d), .cnt_o(word_count), .inj_cnt_o(unused_inj_cnt0)
  );

  stream_pattern_lane #(.NLINKS(NLINKS), .CNT_WIDTH(CNT_WIDTH), .INJ_EN(1'b1)) u_lane1 (
    .clk, .areset,
    .load_i(load), .abort_i(abort_eff), .mode_i(pat_mode_e'(mode)),
    .seed_i(seed), .burst_len_i(burst_len),
    .inj_i(inject_err), .inj_link_i(inject_link),
    .tready_i(M_AXIS_1_TREADY), .tdata_o(M_AXIS_1_TDATA), .tvalid_o(M_AXIS_1_TVALID),
    .vld_d_o(v1_d), .fin_d_o(f1_d), .cnt_o(unused_cnt1), .inj_cnt_o(inject_count)
  );

  always_ff @(posedge clk) begin
    if (areset) begin
      state_q <= ST_IDLE;
      abort_q <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            state_q <= ST_RUN;
            abort_q <= 1'b0;
          end
        end
        ST_RUN: begin
          if (stop) abort_q <= 1'b1;
          if (f0_d && f1_d) begin
            state_q <= ST_DONE;
          end else if (abort_eff && !v0_d && !v1_d) begin
            state_q <= ST_IDLE;
            abort_q <= 1'b0;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign busy = (state_q == ST_RUN);
  assign done = (state_q == ST_DONE);

endmodule
